sfx_sequencer: RTL

- Upstream audio stage between game control logic and the game-over melody generator.
- Converts single-cycle gameplay event pulses (rotate, drop, line clear, game over) into short prioritised sound-effect note sequences on its own square-wave output.
- Owns the level that enables the game-over melody generator, holding it until restart.

---
 rtl/sfx_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: turns gameplay event pulses into prioritised square-wave
// note sequences and owns the level enable of the game-over melody generator.
module sfx_sequencer #(
   parameter int unsigned FCLK     = 50000000,
   parameter int unsigned TICK_DIV = FCLK / 1000,
   parameter int unsigned GAP_MS   = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       evt_rotate,
   input  logic       evt_drop,
   input  logic [2:0] evt_clear,
   input  logic       evt_game_over,
   input  logic       game_restart,
   input  logic       mute,
   output logic       spkr_sfx,
   output logic       melody_en,
   output logic       busy,
   output logic [2:0] cur_effect
);

   localparam int unsigned ACC_W  = 32;
   localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned MS_W   = 16;
   localparam int unsigned EFF_W  = 3;
   localparam int unsigned FREQ_W = 16;

   localparam logic [EFF_W-1:0] EFF_NONE  = 3'd0;
   localparam logic [EFF_W-1:0] EFF_ROT   = 3'd1;
   localparam logic [EFF_W-1:0] EFF_DROP  = 3'd2;
   localparam logic [EFF_W-1:0] EFF_CLEAR = 3'd3;
   localparam logic [EFF_W-1:0] EFF_OVER  = 3'd4;

   typedef enum logic [1:0] {IDLE, PLAY, GAP, OVER} state_e;

   // Note frequency in Hz for a given effect and note index.
   function automatic logic [FREQ_W-1:0] note_freq(input logic [EFF_W-1:0] eff,
                                                   input logic [2:0] idx);
      logic [FREQ_W-1:0] f;
      f = '0;
      case (eff)
         EFF_ROT:  f = 16'd880;
         EFF_DROP: f = (idx == 3'd0) ? 16'd220 : 16'd165;
         EFF_CLEAR: begin
            case (idx)
               3'd0:    f = 16'd523;
               3'd1:    f = 16'd659;
               3'd2:    f = 16'd784;
               3'd3:    f = 16'd1047;
               default: f = 16'd1319;
            endcase
         end
         default: f = '0;
      endcase
      return f;
   endfunction

   function automatic logic [MS_W-1:0] note_dur(input logic [EFF_W-1:0] eff);
      logic [MS_W-1:0] d;
      d = '0;
      case (eff)
         EFF_ROT:   d = MS_W'(30);
         EFF_DROP:  d = MS_W'(40);
         EFF_CLEAR: d = MS_W'(60);
         default:   d = '0;
      endcase
      return d;
   endfunction

   state_e             state_q, state_d;
   logic               pend_rot_q, pend_rot_d;
   logic               pend_drop_q, pend_drop_d;
   logic               pend_clr_q, pend_clr_d;
   logic [2:0]         pend_n_q, pend_n_d;
   logic [EFF_W-1:0]   eff_q, eff_d;
   logic [2:0]         note_q, note_d;
   logic [2:0]         last_q, last_d;
   logic [MS_W-1:0]    ms_q, ms_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               tone_q, tone_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               spkr_q, spkr_d;
   logic               mel_q, mel_d;
   logic               busy_q, busy_d;

   logic               tick_c;
   logic [2:0]         clr_n_c;
   logic               p_rot_c, p_drop_c, p_clr_c;
   logic [2:0]         p_n_c;
   logic [EFF_W-1:0]   best_c;

   // Free-running 1 ms tick divider.
   always_comb begin
      tick_c = (div_q == DIV_W'(TICK_DIV - 1));
      div_d  = tick_c ? '0 : div_q + DIV_W'(1);
   end

   // Pending set merged with this cycle's pulses, and the winner by priority.
   always_comb begin
      clr_n_c  = (evt_clear > 3'd4) ? 3'd4 : evt_clear;
      p_rot_c  = pend_rot_q | evt_rotate;
      p_drop_c = pend_drop_q | evt_drop;
      p_clr_c  = pend_clr_q | (evt_clear != 3'd0);
      p_n_c    = (evt_clear != 3'd0) ? clr_n_c : pend_n_q;
      if (p_clr_c)       best_c = EFF_CLEAR;
      else if (p_drop_c) best_c = EFF_DROP;
      else if (p_rot_c)  best_c = EFF_ROT;
      else               best_c = EFF_NONE;
   end

   always_comb begin
      state_d     = state_q;
      pend_rot_d  = p_rot_c;
      pend_drop_d = p_drop_c;
      pend_clr_d  = p_clr_c;
      pend_n_d    = p_n_c;
      eff_d       = eff_q;
      note_d      = note_q;
      last_d      = last_q;
      ms_d        = ms_q;
      acc_d       = acc_q;
      tone_d      = tone_q;
      mel_d       = mel_q;

      if (evt_game_over) begin
         state_d     = OVER;
         pend_rot_d  = 1'b0;
         pend_drop_d = 1'b0;
         pend_clr_d  = 1'b0;
         eff_d       = EFF_OVER;
         mel_d       = 1'b1;
      end else if (state_q == OVER) begin
         // Gameplay events are dropped entirely while the melody owns the speaker.
         pend_rot_d  = 1'b0;
         pend_drop_d = 1'b0;
         pend_clr_d  = 1'b0;
         if (game_restart) begin
            state_d = IDLE;
            eff_d   = EFF_NONE;
            mel_d   = 1'b0;
         end
      end else if (game_restart) begin
         state_d     = IDLE;
         pend_rot_d  = 1'b0;
         pend_drop_d = 1'b0;
         pend_clr_d  = 1'b0;
         eff_d       = EFF_NONE;
      end else if (best_c != EFF_NONE && (state_q == IDLE || best_c > eff_q)) begin
         state_d = PLAY;
         eff_d   = best_c;
         note_d  = 3'd0;
         ms_d    = note_dur(best_c);
         acc_d   = '0;
         tone_d  = 1'b0;
         case (best_c)
            EFF_CLEAR: begin pend_clr_d = 1'b0;  last_d = p_n_c; end
            EFF_DROP:  begin pend_drop_d = 1'b0; last_d = 3'd1;  end
            default:   begin pend_rot_d = 1'b0;  last_d = 3'd0;  end
         endcase
      end else begin
         case (state_q)
            PLAY: begin
               if (ms_q == '0) begin
                  acc_d  = '0;
                  tone_d = 1'b0;
                  if (note_q != last_q) begin
                     state_d = GAP;
                     ms_d    = MS_W'(GAP_MS);
                  end else begin
                     state_d = IDLE;
                     eff_d   = EFF_NONE;
                  end
               end else begin
                  if (tick_c) ms_d = ms_q - MS_W'(1);
                  if (acc_q >= ACC_W'(FCLK)) begin
                     acc_d  = acc_q - ACC_W'(FCLK);
                     tone_d = ~tone_q;
                  end else begin
                     acc_d = acc_q + (ACC_W'(note_freq(eff_q, note_q)) << 1);
                  end
               end
            end
            GAP: begin
               if (ms_q == '0) begin
                  state_d = PLAY;
                  note_d  = note_q + 3'd1;
                  ms_d    = note_dur(eff_q);
                  acc_d   = '0;
                  tone_d  = 1'b0;
               end else if (tick_c) begin
                  ms_d = ms_q - MS_W'(1);
               end
            end
            default: ;
         endcase
      end

      spkr_d = (state_d == PLAY) & tone_d & ~mute;
      busy_d = (state_d == PLAY) || (state_d == GAP);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pend_rot_q  <= 1'b0;
         pend_drop_q <= 1'b0;
         pend_clr_q  <= 1'b0;
         pend_n_q    <= '0;
         eff_q       <= EFF_NONE;
         note_q      <= '0;
         last_q      <= '0;
         ms_q        <= '0;
         acc_q       <= '0;
         tone_q      <= 1'b0;
         div_q       <= '0;
         spkr_q      <= 1'b0;
         mel_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_rot_q  <= pend_rot_d;
         pend_drop_q <= pend_drop_d;
         pend_clr_q  <= pend_clr_d;
         pend_n_q    <= pend_n_d;
         eff_q       <= eff_d;
         note_q      <= note_d;
         last_q      <= last_d;
         ms_q        <= ms_d;
         acc_q       <= acc_d;
         tone_q      <= tone_d;
         div_q       <= div_d;
         spkr_q      <= spkr_d;
         mel_q       <= mel_d;
         busy_q      <= busy_d;
      end
   end

   assign spkr_sfx   = spkr_q;
   assign melody_en  = mel_q;
   assign busy       = busy_q;
   assign cur_effect = eff_q;

endmodule
